uart_tx_arbiter: RTL

- Shares the single UART transmitter between two byte sources:
  - Port A: RX echo path from Control.
  - Port B: status/error message generator.
- Each port has a small ready/valid FIFO. A round-robin or strict-priority arbiter drains the FIFOs and sequences TX through its `write_en`/`busy_out` handshake.
- Sits between the requesters and the TX instance. It drives TX `real_data_in` and `write_en`, and observes `busy_out`.

---
 rtl/uart_tx_arbiter_if.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the two byte requesters, the TX instance and uart_tx_arbiter.
// The master side drives the requests and TX busy; the slave side is the arbiter itself.
interface uart_tx_arbiter_if #(
    parameter int DEPTH = 4
) ();
    localparam int LW = $clog2(DEPTH) + 1;

    logic [7:0]    a_data;
    logic          a_valid;
    logic          a_ready;
    logic [7:0]    b_data;
    logic          b_valid;
    logic          b_ready;
    logic          prio_a;
    logic          tx_busy;
    logic          tx_write_en;
    logic [7:0]    tx_data;
    logic [LW-1:0] a_level;
    logic [LW-1:0] b_level;
    logic          last_grant;
    logic          busy_timeout;
    logic          idle;

    modport master (
        output a_data, a_valid, b_data, b_valid, prio_a, tx_busy,
        input  a_ready, b_ready, tx_write_en, tx_data, a_level, b_level,
               last_grant, busy_timeout, idle
    );

    modport slave (
        input  a_data, a_valid, b_data, b_valid, prio_a, tx_busy,
        output a_ready, b_ready, tx_write_en, tx_data, a_level, b_level,
               last_grant, busy_timeout, idle
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between an RX echo source (A) and a status source (B).
// Each source has a small FIFO; the FSM issues one byte at a time and watches TX busy.
module uart_tx_arbiter #(
    parameter int DEPTH     = 4,
    parameter int BUSY_WAIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(BUSY_WAIT + 1);

    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_ZERO = LW'(0);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] PTR_ZERO = PW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_WAIT_LO = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          timeout_q, timeout_d;
    logic          last_grant_q, last_grant_d;
    logic          write_en_q, write_en_d;
    logic [7:0]    tx_data_q, tx_data_d;

    logic [7:0]    mem_q   [2][DEPTH];
    logic [PW-1:0] wptr_q  [2];
    logic [PW-1:0] rptr_q  [2];
    logic [LW-1:0] level_q [2];
    logic [LW-1:0] level_d [2];

    logic [7:0]    in_data_s [2];
    logic [7:0]    head_s    [2];
    logic [1:0]    in_valid_s;
    logic [1:0]    ready_s;
    logic [1:0]    push_s;
    logic [1:0]    pop_s;
    logic [1:0]    nonempty_s;
    logic          grant_s;

    // Index 0 is port A, index 1 is port B everywhere below.
    assign in_data_s[0]  = bus.a_data;
    assign in_data_s[1]  = bus.b_data;
    assign in_valid_s[0] = bus.a_valid;
    assign in_valid_s[1] = bus.b_valid;

    for (genvar p = 0; p < 2; p++) begin : g_port
        assign ready_s[p]    = (level_q[p] != LVL_FULL);
        assign push_s[p]     = in_valid_s[p] & ready_s[p];
        assign nonempty_s[p] = (level_q[p] != LVL_ZERO);
        assign head_s[p]     = mem_q[p][rptr_q[p]];
    end

    // Occupancy next state; a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            case ({push_s[p], pop_s[p]})
                2'b10:   level_d[p] = level_q[p] + LVL_ONE;
                2'b01:   level_d[p] = level_q[p] - LVL_ONE;
                default: level_d[p] = level_q[p];
            endcase
        end
    end

    // FIFO storage, pointers and occupancy for both ports.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < 2; p++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[p][i] <= 8'h00;
                end
                wptr_q[p]  <= PTR_ZERO;
                rptr_q[p]  <= PTR_ZERO;
                level_q[p] <= LVL_ZERO;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (push_s[p]) begin
                    mem_q[p][wptr_q[p]] <= in_data_s[p];
                    wptr_q[p]           <= wptr_q[p] + PTR_ONE;
                end
                if (pop_s[p]) begin
                    rptr_q[p] <= rptr_q[p] + PTR_ONE;
                end
                level_q[p] <= level_d[p];
            end
        end
    end

    // Grant select: strict priority favours A, round robin alternates away from the last winner.
    always_comb begin
        if (nonempty_s[0] && nonempty_s[1]) begin
            grant_s = bus.prio_a ? 1'b0 : ~last_grant_q;
        end else begin
            grant_s = nonempty_s[1];
        end
    end

    // Issue/wait sequencing: one byte in flight, busy must rise within BUSY_WAIT cycles.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        timeout_d    = timeout_q;
        last_grant_d = last_grant_q;
        tx_data_d    = tx_data_q;
        write_en_d   = 1'b0;
        pop_s        = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (!bus.tx_busy && (nonempty_s != 2'b00)) begin
                    pop_s[grant_s] = 1'b1;
                    tx_data_d      = head_s[grant_s];
                    write_en_d     = 1'b1;
                    last_grant_d   = grant_s;
                    wait_cnt_d     = CNT_ZERO;
                    state_d        = ST_WAIT_HI;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_HI: begin
                if (bus.tx_busy) begin
                    wait_cnt_d = CNT_ZERO;
                    state_d    = ST_WAIT_LO;
                end else if (wait_cnt_q == CNT_LAST) begin
                    wait_cnt_d = CNT_ZERO;
                    timeout_d  = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_LO: begin
                if (!bus.tx_busy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_LO;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state and registered TX-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= CNT_ZERO;
            timeout_q    <= 1'b0;
            last_grant_q <= 1'b1;
            write_en_q   <= 1'b0;
            tx_data_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            timeout_q    <= timeout_d;
            last_grant_q <= last_grant_d;
            write_en_q   <= write_en_d;
            tx_data_q    <= tx_data_d;
        end
    end

    assign bus.a_ready      = ready_s[0];
    assign bus.b_ready      = ready_s[1];
    assign bus.a_level      = level_q[0];
    assign bus.b_level      = level_q[1];
    assign bus.tx_write_en  = write_en_q;
    assign bus.tx_data      = tx_data_q;
    assign bus.last_grant   = last_grant_q;
    assign bus.busy_timeout = timeout_q;
    assign bus.idle         = (state_q == ST_IDLE) && (nonempty_s == 2'b00);
endmodule
